// File: rtl/calcula_distancias_pkg.sv
// Shared definitions for the distance engine and the minimum-distance selector.
// Fixed class count, default distance width, FSM states, packed-bus slice helper.
package calcula_distancias_pkg;

   localparam int N_CLASSES  = 10;
   localparam int DIST_W_DEF = 32;
   localparam int CLASSE_W   = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACUM    = 2'd1,
      DRENA   = 2'd2,
      PUBLICA = 2'd3
   } estado_t;

   // Offset of class k inside a packed N_CLASSES*w distance bus.
   function automatic int class_off(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/modelo_mem.sv
// Template store: N_CLASSES x N_FEATURES elements, one sync write, ten async read lanes.
// Latency: write commits at the clock edge, reads are combinational on rd_idx.
// Backpressure: none; writes to class codes beyond the last class are dropped.
module modelo_mem
   import calcula_distancias_pkg::*;
#(
   parameter  int N_FEATURES = 64,
   parameter  int FEAT_W     = 8,
   localparam int IDX_W      = $clog2(N_FEATURES)
) (
   input  logic                               iCLK,
   input  logic                               wr_vld,
   input  logic [CLASSE_W-1:0]                wr_classe,
   input  logic [IDX_W-1:0]                   wr_idx,
   input  logic [FEAT_W-1:0]                  wr_dat,
   input  logic [IDX_W-1:0]                   rd_idx,
   output logic [N_CLASSES-1:0][FEAT_W-1:0]   rd_dat
);

   logic [FEAT_W-1:0] mem [N_CLASSES][N_FEATURES];

   // Template contents survive reset, so the array has no reset branch.
   always_ff @(posedge iCLK) begin
      for (int k = 0; k < N_CLASSES; k++) begin
         if (wr_vld && (wr_classe == CLASSE_W'(k))) begin
            mem[k][wr_idx] <= wr_dat;
         end
      end
   end

   always_comb begin
      rd_dat = '0;
      for (int k = 0; k < N_CLASSES; k++) begin
         rd_dat[k] = mem[k][rd_idx];
      end
   end

endmodule

// File: rtl/calcula_distancias.sv
// SAD engine: one streamed feature vector against ten templates in parallel.
// Latency: result, valido and done visible two edges after the last sample handshake.
// Backpressure: amostra_ready high only in ACUM; valid gaps just insert pipeline bubbles.
module calcula_distancias
   import calcula_distancias_pkg::*;
#(
   parameter  int N_FEATURES = 64,
   parameter  int FEAT_W     = 8,
   parameter  int DIST_W     = DIST_W_DEF,
   localparam int IDX_W      = $clog2(N_FEATURES)
) (
   input  logic                          iCLK,
   input  logic                          iRST_N,
   input  logic                          inicio,
   input  logic                          amostra_valid,
   input  logic [FEAT_W-1:0]             amostra,
   output logic                          amostra_ready,
   input  logic                          modelo_we,
   input  logic [CLASSE_W-1:0]           modelo_classe,
   input  logic [IDX_W-1:0]              modelo_idx,
   input  logic [FEAT_W-1:0]             modelo_dado,
   output logic [N_CLASSES*DIST_W-1:0]   v_diferenca,
   output logic                          valido,
   output logic                          done,
   output logic                          ocupado
);

   estado_t                             estado;
   logic [IDX_W-1:0]                    cnt;
   logic                                pipe_vld;
   logic [N_CLASSES-1:0][FEAT_W-1:0]    dif_q;
   logic [N_CLASSES-1:0][FEAT_W-1:0]    dif_d;
   logic [N_CLASSES-1:0][FEAT_W-1:0]    modelo_rd;
   logic [N_CLASSES-1:0][DIST_W-1:0]    acum;
   logic [N_CLASSES-1:0][DIST_W-1:0]    acum_sat;
   logic [N_CLASSES-1:0][DIST_W:0]      soma;
   logic                                hs;
   logic                                ultimo;
   logic                                mem_we;

   assign hs     = amostra_valid & amostra_ready;
   assign ultimo = (cnt == IDX_W'(N_FEATURES - 1));
   assign mem_we = modelo_we & (estado == IDLE);

   modelo_mem #(
      .N_FEATURES (N_FEATURES),
      .FEAT_W     (FEAT_W)
   ) u_modelo_mem (
      .iCLK      (iCLK),
      .wr_vld    (mem_we),
      .wr_classe (modelo_classe),
      .wr_idx    (modelo_idx),
      .wr_dat    (modelo_dado),
      .rd_idx    (cnt),
      .rd_dat    (modelo_rd)
   );

   // Stage 1 operands and stage 2 saturating sum; one carry bit catches overflow.
   always_comb begin
      dif_d    = '0;
      soma     = '0;
      acum_sat = '0;
      for (int k = 0; k < N_CLASSES; k++) begin
         dif_d[k]    = (amostra >= modelo_rd[k]) ? (amostra - modelo_rd[k])
                                                 : (modelo_rd[k] - amostra);
         soma[k]     = {1'b0, acum[k]} + (DIST_W + 1)'(dif_q[k]);
         acum_sat[k] = soma[k][DIST_W] ? {DIST_W{1'b1}} : soma[k][DIST_W-1:0];
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         estado        <= IDLE;
         cnt           <= '0;
         pipe_vld      <= 1'b0;
         dif_q         <= '0;
         acum          <= '0;
         v_diferenca   <= '0;
         valido        <= 1'b0;
         done          <= 1'b0;
         amostra_ready <= 1'b0;
         ocupado       <= 1'b0;
      end else begin
         done     <= 1'b0;
         pipe_vld <= 1'b0;
         if (pipe_vld) begin
            acum <= acum_sat;
         end
         case (estado)
            IDLE: begin
               if (inicio) begin
                  acum          <= '0;
                  cnt           <= '0;
                  valido        <= 1'b0;
                  amostra_ready <= 1'b1;
                  ocupado       <= 1'b1;
                  estado        <= ACUM;
               end
            end
            ACUM: begin
               if (hs) begin
                  dif_q    <= dif_d;
                  pipe_vld <= 1'b1;
                  cnt      <= cnt + 1'b1;
                  if (ultimo) begin
                     amostra_ready <= 1'b0;
                     estado        <= DRENA;
                  end
               end
            end
            DRENA: begin
               estado <= PUBLICA;
            end
            PUBLICA: begin
               for (int k = 0; k < N_CLASSES; k++) begin
                  v_diferenca[class_off(k, DIST_W) +: DIST_W] <= acum[k];
               end
               valido  <= 1'b1;
               done    <= 1'b1;
               ocupado <= 1'b0;
               estado  <= IDLE;
            end
            default: begin
               estado <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_calcula_distancias.sv
// Bench: a 32-bit and an 8-bit distance engine share stimulus; scoreboard queues hold
// expected buses pushed at start and popped when done is due.
module tb_calcula_distancias;
   import calcula_distancias_pkg::*;

   localparam int NF = 4;
   localparam int FW = 8;

   logic            iCLK = 1'b0;
   logic            iRST_N = 1'b0;
   logic            inicio = 1'b0;
   logic            amostra_valid = 1'b0;
   logic [FW-1:0]   amostra = '0;
   logic            modelo_we = 1'b0;
   logic [3:0]      modelo_classe = '0;
   logic [1:0]      modelo_idx = '0;
   logic [FW-1:0]   modelo_dado = '0;

   logic            ready32, valido32, done32, ocup32;
   logic            ready8, valido8, done8, ocup8;
   logic [319:0]    v32;
   logic [79:0]     v8;

   int              n_vec = 0;
   int              n_err = 0;
   int              n_done = 0;
   int              tmpl [N_CLASSES][NF];
   logic [319:0]    q32 [$];
   logic [79:0]     q8 [$];
   logic [319:0]    last32 = '0;
   logic [79:0]     last8 = '0;

   always #5 iCLK = ~iCLK;

   always @(negedge iCLK) if (done32 === 1'b1) n_done++;

   calcula_distancias #(.N_FEATURES(NF), .FEAT_W(FW), .DIST_W(32)) dut32 (
      .iCLK(iCLK), .iRST_N(iRST_N), .inicio(inicio), .amostra_valid(amostra_valid),
      .amostra(amostra), .amostra_ready(ready32), .modelo_we(modelo_we),
      .modelo_classe(modelo_classe), .modelo_idx(modelo_idx), .modelo_dado(modelo_dado),
      .v_diferenca(v32), .valido(valido32), .done(done32), .ocupado(ocup32)
   );

   calcula_distancias #(.N_FEATURES(NF), .FEAT_W(FW), .DIST_W(8)) dut8 (
      .iCLK(iCLK), .iRST_N(iRST_N), .inicio(inicio), .amostra_valid(amostra_valid),
      .amostra(amostra), .amostra_ready(ready8), .modelo_we(modelo_we),
      .modelo_classe(modelo_classe), .modelo_idx(modelo_idx), .modelo_dado(modelo_dado),
      .v_diferenca(v8), .valido(valido8), .done(done8), .ocupado(ocup8)
   );

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic push_expected(input int s [NF]);
      logic [319:0] e32;
      logic [79:0]  e8;
      e32 = '0;
      e8  = '0;
      for (int k = 0; k < N_CLASSES; k++) begin
         int d;
         d = 0;
         for (int i = 0; i < NF; i++) begin
            d += (s[i] >= tmpl[k][i]) ? (s[i] - tmpl[k][i]) : (tmpl[k][i] - s[i]);
         end
         e32[k*32 +: 32] = 32'(d);
         e8[k*8 +: 8]    = (d > 255) ? 8'hff : 8'(d);
      end
      q32.push_back(e32);
      q8.push_back(e8);
   endtask

   task automatic write_tmpl(input int c, input int i, input int v);
      modelo_we     = 1'b1;
      modelo_classe = 4'(c);
      modelo_idx    = 2'(i);
      modelo_dado   = 8'(v);
      tick();
      modelo_we = 1'b0;
      if (c < N_CLASSES) tmpl[c][i] = v;
   endtask

   // One complete vector; poke pulses inicio and modelo_we during every gap cycle.
   task automatic do_run(input int s [NF], input int g [NF], input bit poke);
      int done_before;
      logic [319:0] e32;
      logic [79:0]  e8;
      done_before = n_done;
      push_expected(s);
      inicio = 1'b1;
      tick();
      inicio = 1'b0;
      check_bit("valido_drop", valido32, 1'b0);
      n_vec++;
      if (v32 !== last32 || v8 !== last8) begin
         n_err++;
         $display("FAIL hold_after_inicio: got %h / %h, expected %h / %h", v32, v8, last32, last8);
      end
      for (int i = 0; i < NF; i++) begin
         for (int j = 0; j < g[i]; j++) begin
            amostra_valid = 1'b0;
            if (poke) begin
               inicio        = 1'b1;
               modelo_we     = 1'b1;
               modelo_classe = 4'd3;
               modelo_idx    = 2'(i);
               modelo_dado   = 8'd99;
            end
            check_bit("ready_gap", ready32 & ready8, 1'b1);
            tick();
            inicio    = 1'b0;
            modelo_we = 1'b0;
         end
         amostra_valid = 1'b1;
         amostra       = 8'(s[i]);
         check_bit("ready_acum", ready32 & ready8 & ocup32, 1'b1);
         tick();
      end
      amostra_valid = 1'b0;
      check_bit("ready_drop", ready32 | ready8, 1'b0);
      check_bit("done_edge_k", done32, 1'b0);
      tick();
      check_bit("done_edge_k1", done32 | done8, 1'b0);
      check_bit("ocupado_drena", ocup32, 1'b1);
      tick();
      check_bit("done_edge_k2", done32 & done8, 1'b1);
      check_bit("valido_pub", valido32 & valido8, 1'b1);
      check_bit("ocupado_pub", ocup32 | ocup8, 1'b0);
      n_vec++;
      if (q32.size() == 0 || q8.size() == 0) begin
         n_err++;
         $display("FAIL scoreboard_empty: got result, expected none pending");
      end else begin
         e32 = q32.pop_front();
         e8  = q8.pop_front();
         if (v32 !== e32) begin
            n_err++;
            $display("FAIL dist32: got %h, expected %h", v32, e32);
         end
         n_vec++;
         if (v8 !== e8) begin
            n_err++;
            $display("FAIL dist8: got %h, expected %h", v8, e8);
         end
         last32 = e32;
         last8  = e8;
      end
      tick();
      check_bit("done_pulse_end", done32 | done8, 1'b0);
      n_vec++;
      if (n_done != done_before + 1) begin
         n_err++;
         $display("FAIL done_count: got %0d pulses, expected 1", n_done - done_before);
      end
   endtask

   task automatic test_reset();
      #2;
      check_bit("rst_valido", valido32 | valido8, 1'b0);
      check_bit("rst_done", done32 | done8, 1'b0);
      check_bit("rst_ready", ready32 | ready8, 1'b0);
      check_bit("rst_ocupado", ocup32 | ocup8, 1'b0);
      n_vec++;
      if (v32 !== '0 || v8 !== '0) begin
         n_err++;
         $display("FAIL rst_dist: got %h / %h, expected 0", v32, v8);
      end
      tick();
      iRST_N = 1'b1;
      tick();
   endtask

   task automatic test_load_templates();
      for (int k = 0; k < N_CLASSES; k++)
         for (int i = 0; i < NF; i++)
            write_tmpl(k, i, 10 * k);
      // Out-of-range class codes must not alias onto a real template.
      write_tmpl(12, 0, 200);
      write_tmpl(15, 2, 77);
   endtask

   task automatic test_back_to_back();
      int s [NF];
      int g [NF];
      s = '{25, 25, 25, 25};
      g = '{0, 0, 0, 0};
      do_run(s, g, 1'b0);
      tick();
   endtask

   task automatic test_gaps();
      int s [NF];
      int g [NF];
      s = '{25, 25, 25, 25};
      g = '{0, 0, 3, 1};
      do_run(s, g, 1'b0);
      s = '{0, 90, 45, 200};
      g = '{2, 1, 0, 2};
      do_run(s, g, 1'b0);
   endtask

   task automatic test_saturation();
      int s [NF];
      int g [NF];
      for (int i = 0; i < NF; i++) write_tmpl(0, i, 0);
      s = '{255, 255, 255, 255};
      g = '{0, 0, 0, 0};
      do_run(s, g, 1'b0);
   endtask

   task automatic test_ignored_inputs();
      int s [NF];
      int g [NF];
      s = '{12, 34, 56, 78};
      g = '{1, 2, 0, 1};
      do_run(s, g, 1'b1);
      g = '{0, 0, 0, 0};
      do_run(s, g, 1'b0);
   endtask

   task automatic test_reset_midrun();
      int s [NF];
      int g [NF];
      int done_before;
      done_before = n_done;
      inicio = 1'b1;
      tick();
      inicio        = 1'b0;
      amostra_valid = 1'b1;
      amostra       = 8'd50;
      tick();
      tick();
      amostra_valid = 1'b0;
      iRST_N        = 1'b0;
      #2;
      check_bit("midrst_valido", valido32 | valido8, 1'b0);
      check_bit("midrst_ready", ready32 | ready8, 1'b0);
      check_bit("midrst_ocupado", ocup32 | ocup8, 1'b0);
      n_vec++;
      if (v32 !== '0 || v8 !== '0) begin
         n_err++;
         $display("FAIL midrst_dist: got %h / %h, expected 0", v32, v8);
      end
      tick();
      tick();
      iRST_N = 1'b1;
      last32 = '0;
      last8  = '0;
      repeat (4) tick();
      check_bit("midrst_no_ready", ready32, 1'b0);
      n_vec++;
      if (n_done != done_before) begin
         n_err++;
         $display("FAIL midrst_done: got %0d pulses, expected 0", n_done - done_before);
      end
      s = '{25, 25, 25, 25};
      g = '{0, 1, 0, 0};
      do_run(s, g, 1'b0);
   endtask

   task automatic test_hold();
      int s [NF];
      int g [NF];
      int bad;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         n_vec++;
         if (v32 !== last32 || v8 !== last8 || valido32 !== 1'b1) begin
            n_err++;
            bad++;
            if (bad < 3)
               $display("FAIL hold_idle: got %h valido=%b, expected %h valido=1", v32, valido32, last32);
         end
      end
      s = '{7, 130, 64, 3};
      g = '{0, 0, 0, 0};
      do_run(s, g, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load_templates();
      test_back_to_back();
      test_gaps();
      test_saturation();
      test_ignored_inputs();
      test_reset_midrun();
      test_hold();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
